// File: rtl/sample_iterator_if.sv
// Triangle/box handoff from the bounding-box stage and candidate-sample stream to the sample test stage.
interface sample_iterator_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                   validTri_R13H;
    logic [3:0]                             subSample_RnnnnU;
    logic                                   halt_RnnnnH;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
    logic [1:0][SIGFIG-1:0]                 sample_R14S;
    logic                                   validSamp_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
        output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_iterator.sv
// Raster-walks the sample grid of a triangle's bounding box, one sample per cycle, 1 cycle after accept.
// halt holds upstream for the whole walk except the last-sample cycle, so triangles stream back to back.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic              clk,
    input  logic              rst,
    sample_iterator_if.slave  bus
);
    typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

    state_t                                 r_state, w_state_nxt;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri, w_tri_nxt;
    logic [COLORS-1:0][SIGFIG-1:0]          r_color, w_color_nxt;
    logic [SIGFIG-1:0]                      r_ll_x, w_ll_x_nxt;
    logic [SIGFIG-1:0]                      r_ur_x, w_ur_x_nxt;
    logic [SIGFIG-1:0]                      r_ur_y, w_ur_y_nxt;
    logic [SIGFIG-1:0]                      r_step, w_step_nxt;
    logic [SIGFIG-1:0]                      r_x, w_x_nxt;
    logic [SIGFIG-1:0]                      r_y, w_y_nxt;
    logic                                   r_degen, w_degen_nxt;

    logic [SIGFIG-1:0]   w_step_sel;
    logic signed [SIGFIG:0] w_nx, w_ny;
    logic                w_x_over, w_y_over, w_last, w_halt, w_accept;

    always_comb begin
        w_step_sel = SIGFIG'(1) << RADIX;
        case (bus.subSample_RnnnnU)
            4'b0100: w_step_sel = SIGFIG'(1) << (RADIX - 1);
            4'b0010: w_step_sel = SIGFIG'(1) << (RADIX - 2);
            4'b0001: w_step_sel = SIGFIG'(1) << (RADIX - 3);
            default: w_step_sel = SIGFIG'(1) << RADIX;
        endcase
    end

    // One extra bit so stepping past the box edge never wraps into a false "inside".
    assign w_nx     = $signed({r_x[SIGFIG-1], r_x}) + $signed({1'b0, r_step});
    assign w_ny     = $signed({r_y[SIGFIG-1], r_y}) + $signed({1'b0, r_step});
    assign w_x_over = w_nx > $signed({r_ur_x[SIGFIG-1], r_ur_x});
    assign w_y_over = w_ny > $signed({r_ur_y[SIGFIG-1], r_ur_y});
    assign w_last   = r_degen || (w_x_over && w_y_over);
    assign w_halt   = (r_state == TEST) && !w_last;
    assign w_accept = bus.validTri_R13H && !w_halt;

    always_comb begin
        w_state_nxt = r_state;
        w_tri_nxt   = r_tri;
        w_color_nxt = r_color;
        w_ll_x_nxt  = r_ll_x;
        w_ur_x_nxt  = r_ur_x;
        w_ur_y_nxt  = r_ur_y;
        w_step_nxt  = r_step;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_degen_nxt = r_degen;
        if (w_accept) begin
            w_state_nxt = TEST;
            w_tri_nxt   = bus.tri_R13S;
            w_color_nxt = bus.color_R13U;
            w_ll_x_nxt  = bus.box_R13S[0][0];
            w_ur_x_nxt  = bus.box_R13S[1][0];
            w_ur_y_nxt  = bus.box_R13S[1][1];
            w_step_nxt  = w_step_sel;
            w_x_nxt     = bus.box_R13S[0][0];
            w_y_nxt     = bus.box_R13S[0][1];
            w_degen_nxt = ($signed(bus.box_R13S[1][0]) < $signed(bus.box_R13S[0][0])) ||
                          ($signed(bus.box_R13S[1][1]) < $signed(bus.box_R13S[0][1]));
        end else if (r_state == TEST) begin
            if (w_last) begin
                w_state_nxt = WAIT;
            end else if (w_x_over) begin
                w_x_nxt = r_ll_x;
                w_y_nxt = w_ny[SIGFIG-1:0];
            end else begin
                w_x_nxt = w_nx[SIGFIG-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT;
            r_tri   <= '0;
            r_color <= '0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_step  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_degen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tri   <= w_tri_nxt;
            r_color <= w_color_nxt;
            r_ll_x  <= w_ll_x_nxt;
            r_ur_x  <= w_ur_x_nxt;
            r_ur_y  <= w_ur_y_nxt;
            r_step  <= w_step_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_degen <= w_degen_nxt;
        end
    end

    assign bus.halt_RnnnnH    = w_halt;
    assign bus.tri_R14S       = r_tri;
    assign bus.color_R14U     = r_color;
    assign bus.sample_R14S[0] = r_x;
    assign bus.sample_R14S[1] = r_y;
    assign bus.validSamp_R14H = (r_state == TEST);
endmodule
